// File: rtl/r_alu_seq.sv
// rtl/r_alu_seq.sv - R-type execution unit with single-cycle ALU ops and iterative mult/div into HI/LO
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while busy is low
//   inst_reg  instruction word, funct = inst_reg[5:0]
//   alu_i1    rs operand (also variable shift amount source)
//   alu_i2    rt operand (shifted operand for all shifts)
//   shift     shamt for sll/srl/sra
//   alu_out   registered result, held until the next completed op
//   valid     one-cycle pulse qualifying alu_out/ovf/illegal
//   busy      high while a mult/div is iterating
//   ovf       signed overflow for add/sub
//   illegal   unsupported funct
module r_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      inst_reg,
  input  logic [WIDTH-1:0] alu_i1,
  input  logic [WIDTH-1:0] alu_i2,
  input  logic [SHW-1:0]   shift,
  output logic [WIDTH-1:0] alu_out,
  output logic             valid,
  output logic             busy,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Architectural and output registers
  state_t           state_q;
  logic [SHW-1:0]   count_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             valid_q;
  logic             busy_q;
  logic             ovf_q;
  logic             illegal_q;

  // Iteration working registers; HI/LO are only touched in FIX
  logic [WIDTH-1:0] opa_q;      // multiplicand magnitude
  logic [WIDTH-1:0] opb_q;      // divisor magnitude
  logic [WIDTH-1:0] acc_hi_q;   // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] raw_a_q;    // unmodified rs, needed for divide-by-zero HI
  logic             is_div_q;
  logic             neg_q;      // negate product or quotient
  logic             rneg_q;     // negate remainder
  logic             dz_q;       // divisor was zero

  logic [5:0]       funct;
  logic             unused_inst;
  logic             is_multi;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   vshift;

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             ovf_d;
  logic             illegal_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign funct       = inst_reg[5:0];
  assign unused_inst = ^inst_reg[31:6];

  // mult/multu/div/divu are 0x18..0x1B; funct[0]=0 selects the signed flavour
  assign is_multi  = (funct[5:2] == 4'b0110);
  assign op_signed = ~funct[0];
  assign mag_a     = (op_signed && alu_i1[WIDTH-1]) ? -alu_i1 : alu_i1;
  assign mag_b     = (op_signed && alu_i2[WIDTH-1]) ? -alu_i2 : alu_i2;

  assign sum    = alu_i1 + alu_i2;
  assign diff   = alu_i1 - alu_i2;
  assign vshift = alu_i1[SHW-1:0];

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole {carry, acc_hi, acc_lo} right by one.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);

  // Restoring step: partial remainder stays below the divisor, so the
  // shifted value fits WIDTH+1 bits and the trial's top bit is its sign.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_trial[WIDTH];

  assign prod_fix = neg_q  ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix  = neg_q  ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rneg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    res_d     = '0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (funct)
      F_ADD: begin
        res_d = sum;
        ovf_d = (alu_i1[WIDTH-1] == alu_i2[WIDTH-1]) && (sum[WIDTH-1] != alu_i1[WIDTH-1]);
      end
      F_ADDU: res_d = sum;
      F_SUB: begin
        res_d = diff;
        ovf_d = (alu_i1[WIDTH-1] != alu_i2[WIDTH-1]) && (diff[WIDTH-1] != alu_i1[WIDTH-1]);
      end
      F_SUBU: res_d = diff;
      F_AND:  res_d = alu_i1 & alu_i2;
      F_OR:   res_d = alu_i1 | alu_i2;
      F_XOR:  res_d = alu_i1 ^ alu_i2;
      F_NOR:  res_d = ~(alu_i1 | alu_i2);
      F_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(alu_i1) < $signed(alu_i2))};
      F_SLTU: res_d = {{(WIDTH-1){1'b0}}, (alu_i1 < alu_i2)};
      F_SLL:  res_d = alu_i2 << shift;
      F_SRL:  res_d = alu_i2 >> shift;
      F_SRA:  res_d = $unsigned($signed(alu_i2) >>> shift);
      F_SLLV: res_d = alu_i2 << vshift;
      F_SRLV: res_d = alu_i2 >> vshift;
      F_SRAV: res_d = $unsigned($signed(alu_i2) >>> vshift);
      F_MFHI: res_d = hi_q;
      F_MFLO: res_d = lo_q;
      F_MTHI: hi_d  = alu_i1;
      F_MTLO: lo_d  = alu_i1;
      F_MULT, F_MULTU, F_DIV, F_DIVU: res_d = '0;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      alu_out_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      raw_a_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_multi) begin
              state_q  <= S_ITER;
              busy_q   <= 1'b1;
              count_q  <= '0;
              opa_q    <= mag_a;
              opb_q    <= mag_b;
              raw_a_q  <= alu_i1;
              acc_hi_q <= '0;
              acc_lo_q <= funct[1] ? mag_a : mag_b;
              is_div_q <= funct[1];
              neg_q    <= op_signed & (alu_i1[WIDTH-1] ^ alu_i2[WIDTH-1]);
              rneg_q   <= op_signed & alu_i1[WIDTH-1];
              dz_q     <= (alu_i2 == '0);
            end else begin
              alu_out_q <= res_d;
              ovf_q     <= ovf_d;
              illegal_q <= illegal_d;
              hi_q      <= hi_d;
              lo_q      <= lo_d;
              valid_q   <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (is_div_q) begin
            acc_hi_q <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          count_q <= count_q + SHW'(1);
          if (count_q == LAST) begin
            state_q <= S_FIX;
            count_q <= '0;
          end
        end
        S_FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (dz_q) begin
            lo_q <= '1;
            hi_q <= raw_a_q;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          alu_out_q <= '0;
          ovf_q     <= 1'b0;
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_out = alu_out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_r_alu_seq.sv
// tb/tb_r_alu_seq.sv - Self-checking bench for r_alu_seq (32-bit and 16-bit instances)
module tb_r_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] inst_reg;
  logic [31:0] alu_i1;
  logic [31:0] alu_i2;
  logic [4:0]  shift;
  logic [31:0] alu_out;
  logic        valid;
  logic        busy;
  logic        ovf;
  logic        illegal;

  logic        start16;
  logic [31:0] inst16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [3:0]  sh16;
  logic [15:0] out16;
  logic        valid16;
  logic        busy16;
  logic        ovf16;
  logic        illegal16;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINS = -MAXS - 1;

  logic [5:0] ftab [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                            6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23,
                            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  r_alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_reg(inst_reg),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .shift(shift),
    .alu_out(alu_out), .valid(valid), .busy(busy), .ovf(ovf), .illegal(illegal)
  );

  r_alu_seq #(.WIDTH(16), .SHW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .inst_reg(inst16),
    .alu_i1(a16), .alu_i2(b16), .shift(sh16),
    .alu_out(out16), .valid(valid16), .busy(busy16), .ovf(ovf16), .illegal(illegal16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [5:0] f);
    return (f == 6'h18) || (f == 6'h19) || (f == 6'h1A) || (f == 6'h1B);
  endfunction

  // Reference behaviour: plain 64-bit arithmetic on the architectural meaning of each funct
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] eo, output logic eovf,
                       output logic eill);
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    int vs;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    vs = int'(a % 32);
    eo = 32'd0; eovf = 1'b0; eill = 1'b0;
    case (f)
      6'h20, 6'h22: begin
        r = (f == 6'h20) ? sa + sb : sa - sb;
        eo = r[31:0];
        eovf = (r > MAXS) || (r < MINS);
      end
      6'h21: begin ur = ua + ub; eo = ur[31:0]; end
      6'h23: begin ur = ua - ub; eo = ur[31:0]; end
      6'h24: eo = a & b;
      6'h25: eo = a | b;
      6'h26: eo = a ^ b;
      6'h27: eo = ~(a | b);
      6'h2A: eo = (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: eo = (ua < ub) ? 32'd1 : 32'd0;
      6'h00: eo = b << sh;
      6'h02: eo = b >> sh;
      6'h03: begin r = sb >>> sh; eo = r[31:0]; end
      6'h04: eo = b << vs;
      6'h06: eo = b >> vs;
      6'h07: begin r = sb >>> vs; eo = r[31:0]; end
      6'h10: eo = m_hi;
      6'h12: eo = m_lo;
      6'h11: m_hi = a;
      6'h13: m_lo = a;
      6'h18: begin r = sa * sb; m_hi = r[63:32]; m_lo = r[31:0]; end
      6'h19: begin ur = ua * ub; m_hi = ur[63:32]; m_lo = ur[31:0]; end
      6'h1A: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          r = sa / sb; m_lo = r[31:0];
          r = sa % sb; m_hi = r[31:0];
        end
      end
      6'h1B: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          ur = ua / ub; m_lo = ur[31:0];
          ur = ua % ub; m_hi = ur[31:0];
        end
      end
      default: eill = 1'b1;
    endcase
  endtask

  // Waits for valid after a multi-cycle start; at cycle inj a competing
  // start with changed operands is presented and must be ignored.
  task automatic wait_done(input int inj, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == inj) begin
        start = 1'b1;
        inst_reg = 32'h20;
        alu_i1 = ~alu_i1;
        alu_i2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    logic [31:0] eo;
    logic eovf, eill;
    int lat;
    model(f, a, b, sh, eo, eovf, eill);
    @(negedge clk);
    start = 1'b1; inst_reg = {26'd0, f}; alu_i1 = a; alu_i2 = b; shift = sh;
    @(posedge clk); #1;
    if (is_multi(f)) begin
      chk($sformatf("busy_f%02h", f), {31'd0, busy}, 32'd1);
      wait_done($urandom_range(2, 30), lat);
      chk($sformatf("latency_f%02h", f), 32'(lat), 32'd33);
      chk($sformatf("busy_end_f%02h", f), {31'd0, busy}, 32'd0);
    end
    chk($sformatf("valid_f%02h", f), {31'd0, valid}, 32'd1);
    chk($sformatf("out_f%02h a=%h b=%h", f, a, b), alu_out, eo);
    chk($sformatf("ovf_f%02h", f), {31'd0, ovf}, {31'd0, eovf});
    chk($sformatf("illegal_f%02h", f), {31'd0, illegal}, {31'd0, eill});
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat16;
    logic [5:0] f;
    rst_n = 1'b0; start = 1'b0; inst_reg = '0; alu_i1 = '0; alu_i2 = '0; shift = '0;
    start16 = 1'b0; inst16 = '0; a16 = '0; b16 = '0; sh16 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);

    // Back-to-back single-cycle ops, valid every cycle
    do_op(6'h20, 32'd1, 32'd2, 0);
    do_op(6'h23, 32'd2, 32'd1, 0);
    do_op(6'h20, 32'h7FFF_FFFF, 32'd1, 0);
    do_op(6'h21, 32'h7FFF_FFFF, 32'd1, 0);
    do_op(6'h22, 32'h8000_0000, 32'd1, 0);
    do_op(6'h03, 32'd0, 32'h8000_0000, 5'd4);
    do_op(6'h06, 32'd36, 32'h0000_00F0, 5'd0);
    do_op(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);

    // Multiply / divide with readback; the first mfhi issues in the valid cycle
    do_op(6'h18, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);
    do_op(6'h1A, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);
    do_op(6'h1B, 32'd9, 32'd0, 0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);
    do_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);

    // mthi/mtlo then immediate readback
    do_op(6'h11, 32'hCAFE_0001, 0, 0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h13, 32'hBEEF_0002, 0, 0);
    do_op(6'h12, 0, 0, 0);

    // Reset in the middle of a multu
    @(negedge clk);
    start = 1'b1; inst_reg = 32'h19; alu_i1 = $urandom; alu_i2 = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_valid", {31'd0, valid}, 32'd0);
    do_op(6'h10, 0, 0, 0);
    do_op(6'h12, 0, 0, 0);

    // 16-bit instance: multu 0xFFFF * 0xFFFF
    @(negedge clk);
    start16 = 1'b1; inst16 = 32'h19; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat16 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (valid16) begin lat16 = k; break; end
    end
    chk("w16_latency", 32'(lat16), 32'd17);
    @(negedge clk);
    start16 = 1'b1; inst16 = 32'h10;
    @(posedge clk); #1;
    chk("w16_hi", {16'd0, out16}, 32'h0000_FFFE);
    @(negedge clk);
    inst16 = 32'h12;
    @(posedge clk); #1;
    chk("w16_lo", {16'd0, out16}, 32'h0000_0001);
    start16 = 1'b0;

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
      else f = ftab[$urandom_range(0, 23)];
      do_op(f, rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));
      if (is_multi(f)) begin
        do_op(6'h10, 0, 0, 0);
        do_op(6'h12, 0, 0, 0);
      end
    end

    @(negedge clk) start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
